// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter FSM states, command/response bytes, frame builder.
// Used by the host transmitter and the receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StRts,
    StWait1,
    StShift,
    StWaitIdle,
    StDone,
    StFail
  } tx_state_e;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ECHO     = 8'hEE;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] RSP_ERR      = 8'hFC;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;

  // {stop, odd parity, data}; shifted out LSB first
  function automatic logic [9:0] tx_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command-side handshake and open-drain pad signals of the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;
  logic       rx_inhibit;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;

  // master: command logic plus pad environment; slave: the transmitter
  modport master (
    output tx_data, tx_start, ps2_clk_in, ps2_data_in,
    input  tx_busy, tx_done, tx_error, rx_inhibit, ps2_clk_oe, ps2_data_oe
  );

  modport slave (
    input  tx_data, tx_start, ps2_clk_in, ps2_data_in,
    output tx_busy, tx_done, tx_error, rx_inhibit, ps2_clk_oe, ps2_data_oe
  );
endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the PS/2 clock and data pads plus a falling-edge strobe on clock.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic clk_in,
  input  logic data_in,
  output logic clk_s,
  output logic data_s,
  output logic fall
);

  logic [1:0] clk_sync_q;
  logic [1:0] data_sync_q;
  logic       clk_prev_q;

  // Reset to the idle-high bus level so no spurious edge appears after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], clk_in};
      data_sync_q <= {data_sync_q[0], data_in};
      clk_prev_q  <= clk_sync_q[1];
    end
  end

  assign clk_s  = clk_sync_q[1];
  assign data_s = data_sync_q[1];
  assign fall   = clk_prev_q & ~clk_sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, device-clocked frame, ACK check.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 12000,
  parameter int unsigned START_TIMEOUT  = 1_500_000,
  parameter int unsigned XFER_TIMEOUT   = 200_000
) (
  input logic           clk,
  input logic           rst,
  ps2_host_tx_if.slave  bus
);

  localparam int unsigned MaxA     = (INHIBIT_CYCLES > XFER_TIMEOUT) ? INHIBIT_CYCLES : XFER_TIMEOUT;
  localparam int unsigned MaxCount = (START_TIMEOUT > MaxA) ? START_TIMEOUT : MaxA;
  localparam int unsigned TimerW   = $clog2(MaxCount + 1);

  localparam logic [TimerW-1:0] InhibitLast = TimerW'(INHIBIT_CYCLES - 1);
  localparam logic [TimerW-1:0] StartLast   = TimerW'(START_TIMEOUT - 1);
  localparam logic [TimerW-1:0] XferLast    = TimerW'(XFER_TIMEOUT - 1);

  tx_state_e         state_q, state_d;
  logic [9:0]        sh_q, sh_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              drive_q, drive_d;

  logic clk_s, data_s, fall;

  ps2_line_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .clk_in  (bus.ps2_clk_in),
    .data_in (bus.ps2_data_in),
    .clk_s   (clk_s),
    .data_s  (data_s),
    .fall    (fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sh_q    <= '0;
      cnt_q   <= '0;
      timer_q <= '0;
      drive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      drive_q <= drive_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    timer_d = timer_q + TimerW'(1);
    drive_d = drive_q;
    unique case (state_q)
      StIdle: begin
        timer_d = '0;
        if (bus.tx_start) begin
          sh_d    = tx_frame(bus.tx_data);
          cnt_d   = '0;
          state_d = StInhibit;
        end
      end
      StInhibit: if (timer_q >= InhibitLast) state_d = StRts;
      StRts: begin
        timer_d = '0;
        state_d = StWait1;
      end
      StWait1: begin
        if (fall) begin
          drive_d = ~sh_q[0];
          sh_d    = {1'b1, sh_q[9:1]};
          cnt_d   = 4'd1;
          timer_d = '0;
          state_d = StShift;
        end else if (timer_q >= StartLast) begin
          state_d = StFail;
        end
      end
      StShift: begin
        // 11th falling edge: device pulls data low to acknowledge
        if (fall && cnt_q == 4'd10) begin
          drive_d = 1'b0;
          state_d = data_s ? StFail : StWaitIdle;
        end else if (fall) begin
          drive_d = ~sh_q[0];
          sh_d    = {1'b1, sh_q[9:1]};
          cnt_d   = cnt_q + 4'd1;
        end else if (timer_q >= XferLast) begin
          state_d = StFail;
        end
      end
      StWaitIdle: begin
        if (clk_s && data_s) state_d = StDone;
        else if (timer_q >= XferLast) state_d = StFail;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.ps2_clk_oe  = 1'b0;
    bus.ps2_data_oe = 1'b0;
    bus.tx_done     = 1'b0;
    bus.tx_error    = 1'b0;
    bus.tx_busy     = (state_q != StIdle);
    bus.rx_inhibit  = (state_q != StIdle);
    unique case (state_q)
      StInhibit: bus.ps2_clk_oe = 1'b1;
      StRts: begin
        bus.ps2_clk_oe  = 1'b1;
        bus.ps2_data_oe = 1'b1;
      end
      StWait1: bus.ps2_data_oe = 1'b1;
      StShift: bus.ps2_data_oe = drive_q;
      StDone:  bus.tx_done = 1'b1;
      StFail: begin
        bus.tx_done  = 1'b1;
        bus.tx_error = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a wired-AND pad model and a clocking keyboard model.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int unsigned InhibitCycles = 20;
  localparam int unsigned StartTimeout  = 300;
  localparam int unsigned XferTimeout   = 2000;
  localparam int          Half          = 12;

  typedef struct packed {
    logic [7:0] data;
    logic       ack;
    logic       mid;
    logic [9:0] frame;
    logic       err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;

  ps2_host_tx_if bus ();

  assign bus.ps2_clk_in  = ~(bus.ps2_clk_oe | dev_clk_low);
  assign bus.ps2_data_in = ~(bus.ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES (InhibitCycles),
    .START_TIMEOUT  (StartTimeout),
    .XFER_TIMEOUT   (XferTimeout)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int lone_err = 0;
  int oe_cnt = 0;

  always @(negedge clk) begin
    if (bus.tx_done) done_cnt++;
    if (bus.tx_error) err_cnt++;
    if (bus.tx_error && !bus.tx_done) lone_err++;
    if (bus.ps2_clk_oe) oe_cnt++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic start_tx(input logic [7:0] data);
    @(negedge clk);
    bus.tx_data  = data;
    bus.tx_start = 1'b1;
    @(negedge clk);
    bus.tx_start = 1'b0;
  endtask

  // Waits for inhibit and clock release, then (optionally) clocks out 11 edges.
  // bits[0]=start, bits[8:1]=data LSB first, bits[9]=parity, bits[10]=stop.
  task automatic device(input bit do_clock, input bit ack, output logic [10:0] bits);
    int n;
    bits = '1;
    n = 0;
    while (!bus.ps2_clk_oe && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("inhibit_seen", 32'(bus.ps2_clk_oe), 32'd1);
    n = 0;
    while (bus.ps2_clk_oe && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("clk_released", 32'(bus.ps2_clk_oe), 32'd0);
    if (do_clock) begin
      repeat (30) @(negedge clk);
      bits[0] = bus.ps2_data_in;
      for (int k = 1; k <= 10; k++) begin
        dev_clk_low = 1'b1;
        repeat (Half) @(negedge clk);
        bits[k] = bus.ps2_data_in;
        dev_clk_low = 1'b0;
        repeat (Half) @(negedge clk);
      end
      if (ack) dev_data_low = 1'b1;
      repeat (Half / 2) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (Half) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (Half) @(negedge clk);
      dev_data_low = 1'b0;
    end
  endtask

  task automatic wait_done_cnt(input int base);
    int n;
    n = 0;
    while (done_cnt == base && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic poll_done();
    int n;
    n = 0;
    while (!bus.tx_done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("done_pulse_seen", 32'(bus.tx_done), 32'd1);
  endtask

  vec_t        vecs [4];
  logic [10:0] got;
  int          dbase, ebase, obase, n;

  initial begin
    vecs[0] = '{data: CMD_SET_LEDS, ack: 1'b1, mid: 1'b0, frame: 10'b11_1110_1101, err: 1'b0};
    vecs[1] = '{data: CMD_ENABLE,   ack: 1'b0, mid: 1'b0, frame: 10'b10_1111_0100, err: 1'b1};
    vecs[2] = '{data: 8'h00,        ack: 1'b1, mid: 1'b1, frame: 10'b11_0000_0000, err: 1'b0};
    vecs[3] = '{data: 8'h55,        ack: 1'b1, mid: 1'b0, frame: 10'b11_0101_0101, err: 1'b0};

    bus.tx_data  = 8'h00;
    bus.tx_start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {26'd0, bus.tx_busy, bus.tx_done, bus.tx_error, bus.rx_inhibit,
                            bus.ps2_clk_oe, bus.ps2_data_oe}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_outputs", {26'd0, bus.tx_busy, bus.tx_done, bus.tx_error, bus.rx_inhibit,
                           bus.ps2_clk_oe, bus.ps2_data_oe}, 32'd0);

    // Table-driven frames
    for (int i = 0; i < 4; i++) begin
      dbase = done_cnt;
      ebase = err_cnt;
      obase = oe_cnt;
      start_tx(vecs[i].data);
      check("busy_after_start", 32'(bus.tx_busy), 32'd1);
      check("rx_inhibit_busy", 32'(bus.rx_inhibit), 32'd1);
      if (vecs[i].mid) begin
        fork
          device(1'b1, vecs[i].ack, got);
          begin
            repeat (100) @(negedge clk);
            bus.tx_data  = 8'h55;
            bus.tx_start = 1'b1;
            @(negedge clk);
            bus.tx_start = 1'b0;
          end
        join
      end else begin
        device(1'b1, vecs[i].ack, got);
      end
      wait_done_cnt(dbase);
      check("frame_bits", 32'(got), 32'({vecs[i].frame, 1'b0}));
      check("clk_oe_cycles", 32'(oe_cnt - obase), InhibitCycles + 1);
      check("done_count", 32'(done_cnt - dbase), 32'd1);
      check("error_count", 32'(err_cnt - ebase), 32'(vecs[i].err));
      check("idle_after", {29'd0, bus.tx_busy, bus.ps2_clk_oe, bus.ps2_data_oe}, 32'd0);
    end

    // Device never clocks: start timeout
    start_tx(8'h01);
    n = 0;
    while (!bus.ps2_clk_oe && n < 1000) begin @(negedge clk); n++; end
    n = 0;
    while (bus.ps2_clk_oe && n < 1000) begin @(negedge clk); n++; end
    check("start_bit_held", 32'(bus.ps2_data_oe), 32'd1);
    n = 0;
    while (!bus.tx_done && n < 1000) begin @(negedge clk); n++; end
    check("start_timeout_cycles", 32'(n), StartTimeout);
    check("timeout_error", 32'(bus.tx_error), 32'd1);
    check("timeout_lines", {30'd0, bus.ps2_clk_oe, bus.ps2_data_oe}, 32'd0);
    repeat (5) @(negedge clk);

    // Reset during inhibit drops the clock line immediately
    start_tx(CMD_RESET);
    repeat (4) @(negedge clk);
    check("inhibit_clk_oe", 32'(bus.ps2_clk_oe), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_inhibit_lines", {30'd0, bus.ps2_clk_oe, bus.ps2_data_oe}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Reset mid-SHIFT: lines released, no done pulse, not busy
    start_tx(CMD_RESET);
    n = 0;
    while (!bus.ps2_clk_oe && n < 1000) begin @(negedge clk); n++; end
    n = 0;
    while (bus.ps2_clk_oe && n < 1000) begin @(negedge clk); n++; end
    repeat (30) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      dev_clk_low = 1'b1;
      repeat (Half) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (Half) @(negedge clk);
    end
    dev_clk_low = 1'b1;
    repeat (Half) @(negedge clk);
    check("busy_mid_shift", 32'(bus.tx_busy), 32'd1);
    dbase = done_cnt;
    rst = 1'b1;
    #1;
    check("rst_shift_lines", {30'd0, bus.ps2_clk_oe, bus.ps2_data_oe}, 32'd0);
    dev_clk_low = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    check("rst_not_busy", 32'(bus.tx_busy), 32'd0);
    check("rst_no_done", 32'(done_cnt - dbase), 32'd0);

    // Back-to-back: start held through the DONE cycle is ignored there, accepted in IDLE
    start_tx(CMD_SET_LEDS);
    device(1'b1, 1'b1, got);
    check("b2b_frame1", 32'(got), 32'({10'b11_1110_1101, 1'b0}));
    poll_done();
    check("b2b_done1_ok", 32'(bus.tx_error), 32'd0);
    bus.tx_data  = 8'h33;
    bus.tx_start = 1'b1;
    @(negedge clk);
    check("start_in_done_ignored", 32'(bus.tx_busy), 32'd0);
    check("rx_inhibit_gap", 32'(bus.rx_inhibit), 32'd0);
    bus.tx_data = 8'h02;
    @(negedge clk);
    bus.tx_start = 1'b0;
    check("b2b_busy2", 32'(bus.tx_busy), 32'd1);
    dbase = done_cnt;
    ebase = err_cnt;
    device(1'b1, 1'b1, got);
    wait_done_cnt(dbase);
    check("b2b_frame2", 32'(got), 32'({10'b10_0000_0010, 1'b0}));
    check("b2b_done2", 32'(done_cnt - dbase), 32'd1);
    check("b2b_err2", 32'(err_cnt - ebase), 32'd0);

    check("error_without_done", 32'(lone_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
